// File: rtl/combat_pkg.sv
// Shared constants, round FSM encoding and helpers for combat_resolver.
// Holds fighter animation state codes and default tuning parameters.
package combat_pkg;

    // Fighter animation codes, matching the fighter FSM enum ordering
    localparam logic [5:0] CROUCH       = 6'd20;
    localparam logic [5:0] CROUCHP      = 6'd22;
    localparam logic [5:0] CROUCHPUNISH = 6'd23;
    localparam logic [5:0] JUMP1        = 6'd25;
    localparam logic [5:0] JUMP2        = 6'd26;
    localparam logic [5:0] JUMP3        = 6'd27;
    localparam logic [5:0] JUMP4        = 6'd28;

    // Default tuning values
    localparam int HEALTH_MAX_DEF  = 100;
    localparam int DMG_STRIKE_DEF  = 8;
    localparam int DMG_BLOCKED_DEF = 2;
    localparam int REACH_DEF       = 60;
    localparam int METER_MAX_DEF   = 200;
    localparam int METER_HIT_DEF   = 20;
    localparam int KO_HOLD_DEF     = 120;

    typedef enum logic [1:0] {
        S_FIGHT = 2'd0,
        S_KO    = 2'd1,
        S_CLEAR = 2'd2
    } round_t;

    function automatic logic is_air(input logic [5:0] s);
        return (s >= JUMP1) && (s <= JUMP4);
    endfunction

    function automatic logic is_crouch(input logic [5:0] s);
        return (s == CROUCH) || (s == CROUCHP) || (s == CROUCHPUNISH);
    endfunction

endpackage

// File: rtl/fighter_ledger.sv
// Per-fighter health and special meter store with saturating updates.
// Ports: Clk, Reset, apply (fight tick), restore (clear tick), clr (gen),
//        dmg, gain in; health, meter out.
module fighter_ledger
    import combat_pkg::*;
#(
    parameter int HEALTH_MAX = HEALTH_MAX_DEF,
    parameter int METER_MAX  = METER_MAX_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       apply,
    input  logic       restore,
    input  logic       clr,
    input  logic [7:0] dmg,
    input  logic [9:0] gain,
    output logic [7:0] health,
    output logic [9:0] meter
);

    logic [7:0]  health_d;
    logic [10:0] sum;
    logic [9:0]  meter_d;

    always_comb begin
        health_d = (health > dmg) ? (health - dmg) : 8'd0;
        // One extra bit so the sum cannot wrap before clamping
        sum      = {1'b0, meter} + {1'b0, gain};
        meter_d  = (sum > 11'(METER_MAX)) ? 10'(METER_MAX) : sum[9:0];
        // Launching a special empties the meter even if a hit landed
        if (clr) begin
            meter_d = 10'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            health <= 8'(HEALTH_MAX);
            meter  <= 10'd0;
        end else if (restore) begin
            health <= 8'(HEALTH_MAX);
            meter  <= 10'd0;
        end else if (apply) begin
            health <= health_d;
            meter  <= meter_d;
        end
    end

endmodule

// File: rtl/combat_resolver.sv
// Per-round combat bookkeeping: frame tick, strike resolution, round FSM.
// Ports: Clk, Reset, frame_clk, hit/gen/state/x per fighter in;
//        health, bs, isdead per fighter, round_over, winner out.
module combat_resolver
    import combat_pkg::*;
#(
    parameter int HEALTH_MAX  = HEALTH_MAX_DEF,
    parameter int DMG_STRIKE  = DMG_STRIKE_DEF,
    parameter int DMG_BLOCKED = DMG_BLOCKED_DEF,
    parameter int REACH       = REACH_DEF,
    parameter int METER_MAX   = METER_MAX_DEF,
    parameter int METER_HIT   = METER_HIT_DEF,
    parameter int KO_HOLD     = KO_HOLD_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       hit_a,
    input  logic       hit_b,
    input  logic       gen_a,
    input  logic       gen_b,
    input  logic [5:0] state_a,
    input  logic [5:0] state_b,
    input  logic [9:0] x_a,
    input  logic [9:0] x_b,
    output logic [7:0] health_a,
    output logic [7:0] health_b,
    output logic [9:0] bs_a,
    output logic [9:0] bs_b,
    output logic       isdead_a,
    output logic       isdead_b,
    output logic       round_over,
    output logic [1:0] winner
);

    localparam int KO_W = $clog2(KO_HOLD + 1);

    logic            fc_q;
    logic            tick;
    round_t          state_q, state_d;
    logic [KO_W-1:0] cnt_q, cnt_d;
    logic [1:0]      winner_q, winner_d;
    logic            dead_a_q, dead_a_d;
    logic            dead_b_q, dead_b_d;

    logic [10:0] dx;
    logic        in_reach;
    logic        conn_a, conn_b;
    logic [7:0]  dmg_to_a, dmg_to_b;
    logic [9:0]  gain_a, gain_b;
    logic        ko_a, ko_b;
    logic        fight, restore;

    // Tick is registered so it lands one cycle after the detected edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q <= 1'b0;
            tick <= 1'b0;
        end else begin
            fc_q <= frame_clk;
            tick <= frame_clk & ~fc_q;
        end
    end

    always_comb begin
        dx = (x_a >= x_b) ? ({1'b0, x_a} - {1'b0, x_b})
                          : ({1'b0, x_b} - {1'b0, x_a});
        in_reach = (dx <= 11'(REACH));
        conn_a   = hit_a & in_reach & ~is_air(state_b);
        conn_b   = hit_b & in_reach & ~is_air(state_a);
        dmg_to_b = 8'd0;
        dmg_to_a = 8'd0;
        if (conn_a) begin
            dmg_to_b = is_crouch(state_b) ? 8'(DMG_BLOCKED) : 8'(DMG_STRIKE);
        end
        if (conn_b) begin
            dmg_to_a = is_crouch(state_a) ? 8'(DMG_BLOCKED) : 8'(DMG_STRIKE);
        end
        gain_a = (conn_a ? 10'(METER_HIT) : 10'd0)
               + (conn_b ? 10'(METER_HIT / 2) : 10'd0);
        gain_b = (conn_b ? 10'(METER_HIT) : 10'd0)
               + (conn_a ? 10'(METER_HIT / 2) : 10'd0);
        // Pre-tick health decides the KO, mirroring the ledger saturation
        ko_a    = conn_b & (health_a <= dmg_to_a);
        ko_b    = conn_a & (health_b <= dmg_to_b);
        fight   = tick & (state_q == S_FIGHT);
        restore = tick & (state_q == S_CLEAR);
    end

    fighter_ledger #(
        .HEALTH_MAX (HEALTH_MAX),
        .METER_MAX  (METER_MAX)
    ) u_ledger_a (
        .Clk     (Clk),
        .Reset   (Reset),
        .apply   (fight),
        .restore (restore),
        .clr     (gen_a),
        .dmg     (dmg_to_a),
        .gain    (gain_a),
        .health  (health_a),
        .meter   (bs_a)
    );

    fighter_ledger #(
        .HEALTH_MAX (HEALTH_MAX),
        .METER_MAX  (METER_MAX)
    ) u_ledger_b (
        .Clk     (Clk),
        .Reset   (Reset),
        .apply   (fight),
        .restore (restore),
        .clr     (gen_b),
        .dmg     (dmg_to_b),
        .gain    (gain_b),
        .health  (health_b),
        .meter   (bs_b)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        dead_a_d = dead_a_q;
        dead_b_d = dead_b_q;
        unique case (state_q)
            S_FIGHT: begin
                if (tick && (ko_a || ko_b)) begin
                    state_d  = S_KO;
                    cnt_d    = '0;
                    dead_a_d = ko_a;
                    dead_b_d = ko_b;
                    // B down -> 01 (A won), A down -> 10, both -> 11
                    winner_d = {ko_a, ko_b};
                end
            end
            S_KO: begin
                if (tick) begin
                    if (cnt_q == KO_W'(KO_HOLD - 1)) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (tick) begin
                    state_d  = S_FIGHT;
                    dead_a_d = 1'b0;
                    dead_b_d = 1'b0;
                    winner_d = 2'b00;
                end
            end
            default: begin
                state_d = S_FIGHT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_FIGHT;
            cnt_q    <= '0;
            winner_q <= 2'b00;
            dead_a_q <= 1'b0;
            dead_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            dead_a_q <= dead_a_d;
            dead_b_q <= dead_b_d;
        end
    end

    assign isdead_a   = dead_a_q;
    assign isdead_b   = dead_b_q;
    assign winner     = winner_q;
    assign round_over = (state_q == S_KO);

endmodule

// File: tb/tb_combat_resolver.sv
// Directed testbench for combat_resolver.
// Drives frame ticks with hand-computed expectations for each step.
module tb_combat_resolver;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       hit_a = 1'b0;
    logic       hit_b = 1'b0;
    logic       gen_a = 1'b0;
    logic       gen_b = 1'b0;
    logic [5:0] state_a = 6'd0;
    logic [5:0] state_b = 6'd0;
    logic [9:0] x_a = 10'd100;
    logic [9:0] x_b = 10'd300;
    logic [7:0] health_a, health_b;
    logic [9:0] bs_a, bs_b;
    logic       isdead_a, isdead_b, round_over;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    combat_resolver dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .gen_a      (gen_a),
        .gen_b      (gen_b),
        .state_a    (state_a),
        .state_b    (state_b),
        .x_a        (x_a),
        .x_b        (x_b),
        .health_a   (health_a),
        .health_b   (health_b),
        .bs_a       (bs_a),
        .bs_b       (bs_b),
        .isdead_a   (isdead_a),
        .isdead_b   (isdead_b),
        .round_over (round_over),
        .winner     (winner)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: rising edge on a negedge, high for 3 cycles, then low
    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ha"}, 32'(health_a), 32'd100);
        chk({tag, "_hb"}, 32'(health_b), 32'd100);
        chk({tag, "_ba"}, 32'(bs_a), 32'd0);
        chk({tag, "_bb"}, 32'(bs_b), 32'd0);
        chk({tag, "_da"}, 32'(isdead_a), 32'd0);
        chk({tag, "_db"}, 32'(isdead_b), 32'd0);
        chk({tag, "_ro"}, 32'(round_over), 32'd0);
        chk({tag, "_w"}, 32'(winner), 32'd0);
    endtask

    initial begin
        do_reset();
        chk_reset_vals("rst");

        // Out of reach: dx = 200
        hit_a = 1'b1;
        tick();
        chk("far_hb", 32'(health_b), 32'd100);
        chk("far_ba", 32'(bs_a), 32'd0);

        // Clean strike, dx = 50
        x_b = 10'd150;
        tick();
        chk("clean_hb", 32'(health_b), 32'd92);
        chk("clean_ba", 32'(bs_a), 32'd20);
        chk("clean_bb", 32'(bs_b), 32'd10);

        // dx = 61 just outside reach
        x_b = 10'd161;
        tick();
        chk("r61_hb", 32'(health_b), 32'd92);

        // Reversed order, dx = 60 exactly at reach
        x_a = 10'd160;
        x_b = 10'd100;
        tick();
        chk("r60_hb", 32'(health_b), 32'd84);
        chk("r60_ba", 32'(bs_a), 32'd40);

        // Blocked strike on crouching defender
        state_b = 6'd20;
        tick();
        chk("blk_hb", 32'(health_b), 32'd82);
        chk("blk_ba", 32'(bs_a), 32'd60);
        chk("blk_bb", 32'(bs_b), 32'd30);

        // Whiff against airborne defender
        state_b = 6'd26;
        tick();
        chk("air_hb", 32'(health_b), 32'd82);
        chk("air_ba", 32'(bs_a), 32'd60);

        // Six blocked strikes: meter 60 -> 180
        state_b = 6'd22;
        for (int i = 0; i < 6; i++) tick();
        chk("build_hb", 32'(health_b), 32'd70);
        chk("build_ba", 32'(bs_a), 32'd180);

        // B strikes idle A: A +10 as defender
        hit_a = 1'b0;
        hit_b = 1'b1;
        tick();
        chk("bhit_ha", 32'(health_a), 32'd92);
        chk("bhit_ba", 32'(bs_a), 32'd190);
        chk("bhit_bb", 32'(bs_b), 32'd110);

        // 190 + 20 clamps at 200
        hit_b = 1'b0;
        hit_a = 1'b1;
        state_b = 6'd23;
        tick();
        chk("sat_ba", 32'(bs_a), 32'd200);
        chk("sat_bb", 32'(bs_b), 32'd120);
        chk("sat_hb", 32'(health_b), 32'd68);

        // Gen beats a same-tick gain
        gen_a = 1'b1;
        tick();
        chk("gen_ba", 32'(bs_a), 32'd0);
        chk("gen_bb", 32'(bs_b), 32'd130);
        chk("gen_hb", 32'(health_b), 32'd66);

        gen_a = 1'b0;
        hit_a = 1'b0;
        gen_b = 1'b1;
        tick();
        chk("genb_bb", 32'(bs_b), 32'd0);
        gen_b = 1'b0;

        // Frame held high gives only one tick
        hit_a = 1'b1;
        state_b = 6'd0;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (20) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        chk("hold_hb", 32'(health_b), 32'd58);

        // KO sequence from a fresh round
        hit_a = 1'b0;
        do_reset();
        hit_a = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        state_b = 6'd20;
        tick();
        tick();
        chk("pre_ko_hb", 32'(health_b), 32'd8);
        chk("pre_ko_ba", 32'(bs_a), 32'd200);
        chk("pre_ko_bb", 32'(bs_b), 32'd130);
        chk("pre_ko_ro", 32'(round_over), 32'd0);

        state_b = 6'd0;
        tick();
        chk("ko_hb", 32'(health_b), 32'd0);
        chk("ko_db", 32'(isdead_b), 32'd1);
        chk("ko_da", 32'(isdead_a), 32'd0);
        chk("ko_w", 32'(winner), 32'd1);
        chk("ko_ro", 32'(round_over), 32'd1);
        chk("ko_bb", 32'(bs_b), 32'd140);

        // Everything ignored while KO is held
        hit_b = 1'b1;
        gen_a = 1'b1;
        for (int i = 0; i < 119; i++) tick();
        chk("hold119_ro", 32'(round_over), 32'd1);
        chk("hold119_db", 32'(isdead_b), 32'd1);
        chk("hold119_ha", 32'(health_a), 32'd100);
        chk("hold119_ba", 32'(bs_a), 32'd200);

        tick();
        chk("hold120_ro", 32'(round_over), 32'd0);
        chk("hold120_db", 32'(isdead_b), 32'd1);
        chk("hold120_hb", 32'(health_b), 32'd0);
        chk("hold120_w", 32'(winner), 32'd1);

        tick();
        hit_a = 1'b0;
        hit_b = 1'b0;
        gen_a = 1'b0;
        chk_reset_vals("clr");

        // Double KO: simultaneous strikes
        hit_a = 1'b1;
        hit_b = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("dbl_ha12", 32'(health_a), 32'd12);
        state_a = 6'd20;
        state_b = 6'd20;
        tick();
        tick();
        chk("dbl_ha8", 32'(health_a), 32'd8);
        chk("dbl_hb8", 32'(health_b), 32'd8);
        state_a = 6'd0;
        state_b = 6'd0;
        tick();
        chk("dbl_w", 32'(winner), 32'd3);
        chk("dbl_da", 32'(isdead_a), 32'd1);
        chk("dbl_db", 32'(isdead_b), 32'd1);
        chk("dbl_ro", 32'(round_over), 32'd1);
        hit_a = 1'b0;
        hit_b = 1'b0;
        tick();

        // Reset mid-KO takes effect on the next edge
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        chk_reset_vals("mid_rst");
        Reset = 1'b0;

        // Back in S_FIGHT after reset
        x_a = 10'd100;
        x_b = 10'd150;
        hit_a = 1'b1;
        tick();
        chk("post_hb", 32'(health_b), 32'd92);
        hit_a = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
# combat_resolver

Per-round combat bookkeeping on the opposite side of the fighter animation FSM interface. It consumes each fighter's `hit`/`gen` pulses, animation state codes and positions. It produces the `isdead` and `BS` (special meter) inputs that the fighter FSMs consume, plus health and round status for the HUD. All game updates happen once per frame tick, derived from `frame_clk`.

## Interface
Parameters:
- HEALTH_MAX, 100: starting and restored health.
- DMG_STRIKE, 8: damage for a landed, unblocked strike.
- DMG_BLOCKED, 2: damage when the defender is crouching.
- REACH, 60: maximum |x_a − x_b| in pixels for a strike to connect.
- METER_MAX, 200: meter ceiling; fighters enable the special only at exactly this value.
- METER_HIT, 20: meter gain for the attacker on a connecting strike; the defender gains METER_HIT/2.
- KO_HOLD, 120: number of frames that isdead is held after a KO.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-high.
- frame_clk  in  1  frame strobe; its rising edge is detected internally.
- hit_a, hit_b  in  1  strike level from each fighter FSM.
- gen_a, gen_b  in  1  special-launch level from each fighter FSM.
- state_a, state_b  in  6  fighter animation state codes.
- x_a, x_b  in  10  fighter horizontal positions.
- health_a, health_b  out  8  current health.
- bs_a, bs_b  out  10  special meter, range 0..METER_MAX.
- isdead_a, isdead_b  out  1  KO indication, fed back to the fighter FSMs.
- round_over  out  1  high while in S_KO.
- winner  out  2  01 = A won, 10 = B won, 11 = draw, 00 = none.

## Operation
- Tick generation:
  - Register frame_clk. The tick is one Clk cycle wide and asserts the cycle after a detected rising edge, matching the fighter FSMs.
  - All inputs are sampled only on the tick. Each fighter holds hit and gen for a whole frame, so each event counts exactly once.
- Round FSM with three states: S_FIGHT, S_KO, S_CLEAR.
- S_FIGHT, strike by A (mirror for B):
  - A strike by A connects when hit_a = 1, |x_a − x_b| ≤ REACH, and state_b is not an airborne code (JUMP1..JUMP4).
  - Damage is DMG_BLOCKED if state_b ∈ {CROUCH, CROUCHP, CROUCHPUNISH}, otherwise DMG_STRIKE.
  - Health saturates at 0. Absolute difference is computed at 11 bits, with no wrap.
- S_FIGHT, meter (per fighter):
  - On a connecting strike, the attacker gains METER_HIT and the defender gains METER_HIT/2. Both saturate at METER_MAX.
  - Own gen = 1 clears that fighter's meter to 0. Clear takes priority over any gain in the same tick.
- Simultaneous events:
  - Both strikes in the same tick resolve independently, computed from pre-tick values.
  - If either health reaches 0 on a tick, go to S_KO.
  - Set winner to the surviving fighter, or to 11 if both healths reached 0.
  - isdead_x = 1 for each fighter at 0 health.
- S_KO:
  - Hits and gens are ignored; health and meter are frozen.
  - Count KO_HOLD ticks, then go to S_CLEAR.
- S_CLEAR (one tick):
  - Health returns to HEALTH_MAX, meters go to 0, isdead and winner clear.
  - Return to S_FIGHT.

## Timing
- Reset values: health_a = health_b = HEALTH_MAX; bs = 0; isdead = 0; round_over = 0; winner = 00; FSM = S_FIGHT; KO counter = 0; tick pipeline cleared.
- Latency: outputs change on the Clk edge at which the tick is high and are visible the next cycle. Total is 2 Clk cycles from the frame_clk rising edge.
- isdead asserts on the same edge as health reaching 0, so the fighter FSM sees it on its next frame.
- isdead is held for exactly KO_HOLD ticks of S_KO plus the S_CLEAR tick, then deasserts.
- Reset asserted mid-round or mid-KO returns to the reset values on the next edge, regardless of tick.
- frame_clk held high produces no further ticks.
- Meter arithmetic is computed at 11 bits and then clamped, so 195 + 20 gives 200, not a wrapped value.

## Structure
- Package combat_pkg holds:
  - The fighter state-code constants, matching the fighter enum ordering: CROUCH = 20, CROUCHP = 22, CROUCHPUNISH = 23, JUMP1..JUMP4 = 25..28.
  - The round FSM enum.
  - Default parameter values.
- Sub-module fighter_ledger is instantiated twice, once per fighter. It holds health and meter and applies damage, gain, clear and restore with saturation.
- The top level contains the tick detector, the reach/block/airborne logic, the round FSM and the KO counter.

## Test plan
- Reset and isolation: after reset, health_a = 100 and bs_a = 0. hit_a = 1 with x_a = 100, x_b = 300 gives no change (out of reach).
- Clean strike: x_a = 100, x_b = 150, state_b idle, one tick of hit_a gives health_b = 92, bs_a = 20, bs_b = 10.
- Block and whiff: the same strike gives health_b = 98 with state_b = CROUCH, and no change with state_b = JUMP2.
- Meter saturation and gen priority: bs_a = 190 plus a connecting hit gives 200. A tick with both gen_a and a connecting hit gives bs_a = 0.
- KO sequence: health_b = 8 plus a strike gives isdead_b = 1, winner = 01, round_over = 1. Hits are ignored for 120 ticks, then health is restored to 100 and isdead_b = 0.
- Double KO and reset mid-KO: both healths = 8 with simultaneous strikes gives winner = 11 and both isdead = 1. Reset during S_KO restores all outputs to their reset values on the next Clk edge.
